// File: rtl/ace_snap_restore.sv
// rtl/ace_snap_restore.sv - snapshot register-page capture and T80pa DIR restore engine
// Optional SP sanity fix is built only when ACE_SNAP_SP_FIX_EN is defined.
module ace_snap_restore #(
    parameter logic [7:0]  REG_PAGE      = 8'h21,
    parameter int          VSYNC_WAIT    = 1,
    parameter int          DIRSET_CYCLES = 3,
    parameter logic [15:0] SP_FALLBACK   = 16'hFFFE
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           loader_en,
    input  logic [15:0]    loader_addr,
    input  logic [7:0]     loader_data,
    input  logic           loader_wr,
    input  logic           vsync,
    output logic           cpu_reset,
    output logic           dir_set,
    output logic [211:0]   dir,
    output logic [15:0]    load_top
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT_VS = 2'd2,
        S_APPLY   = 2'd3
    } state_t;

    localparam logic [3:0] VS_LAST = 4'(VSYNC_WAIT - 1);
    localparam logic [3:0] AP_LAST = 4'(DIRSET_CYCLES - 1);

    state_t         state;
    state_t         next_state;
    logic           vsync_d;
    logic           vs_rise;
    logic [3:0]     vs_cnt;
    logic [3:0]     ap_cnt;
    logic           regs_seen;
    logic           entering;
    logic           wr_active;
    logic           off_valid;
    logic           page_hit;
    logic           vs_hit;
    logic [211:0]   dir_wr;

    assign vs_rise   = vsync & ~vsync_d;
    assign vs_hit    = (state == S_WAIT_VS) && vs_rise && (vs_cnt == VS_LAST);
    // A write on the cycle loader_en (re)starts a load belongs to the new load.
    assign entering  = loader_en && (state != S_LOAD);
    assign wr_active = loader_wr && ((state == S_LOAD) || entering);
    assign page_hit  = wr_active && (loader_addr[15:8] == REG_PAGE) &&
                       !loader_addr[7] && off_valid;

    // Register page decode: builds the dir image with the current byte merged in.
    always_comb begin
        dir_wr    = dir;
        off_valid = 1'b1;
        case (loader_addr[6:0])
            7'h00: dir_wr[15:8]    = loader_data;
            7'h01: dir_wr[7:0]     = loader_data;
            7'h04: dir_wr[87:80]   = loader_data;
            7'h05: dir_wr[95:88]   = loader_data;
            7'h08: dir_wr[103:96]  = loader_data;
            7'h09: dir_wr[111:104] = loader_data;
            7'h0C: dir_wr[119:112] = loader_data;
            7'h0D: dir_wr[127:120] = loader_data;
            7'h10: dir_wr[135:128] = loader_data;
            7'h11: dir_wr[143:136] = loader_data;
            7'h14: dir_wr[199:192] = loader_data;
            7'h15: dir_wr[207:200] = loader_data;
            7'h18: dir_wr[55:48]   = loader_data;
            7'h19: dir_wr[63:56]   = loader_data;
            7'h1C: dir_wr[71:64]   = loader_data;
            7'h1D: dir_wr[79:72]   = loader_data;
            7'h20: dir_wr[31:24]   = loader_data;
            7'h21: dir_wr[23:16]   = loader_data;
            7'h24: dir_wr[151:144] = loader_data;
            7'h25: dir_wr[159:152] = loader_data;
            7'h28: dir_wr[167:160] = loader_data;
            7'h29: dir_wr[175:168] = loader_data;
            7'h2C: dir_wr[183:176] = loader_data;
            7'h2D: dir_wr[191:184] = loader_data;
            7'h30: dir_wr[209:208] = loader_data[1:0];
            7'h34: dir_wr[210]     = loader_data[0];
            7'h38: dir_wr[211]     = loader_data[0];
            7'h3C: dir_wr[39:32]   = loader_data;
            7'h40: dir_wr[47:40]   = loader_data;
            default: off_valid     = 1'b0;
        endcase
    end

    // Next-state logic: a live loader always takes priority over vsync and APPLY.
    always_comb begin
        next_state = state;
        if (loader_en) begin
            next_state = S_LOAD;
        end else begin
            case (state)
                S_LOAD:    next_state = S_WAIT_VS;
                S_WAIT_VS: if (vs_hit) next_state = regs_seen ? S_APPLY : S_IDLE;
                S_APPLY:   if (ap_cnt == AP_LAST) next_state = S_IDLE;
                default:   next_state = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from the next state so they switch on the entry edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset <= 1'b0;
            dir_set   <= 1'b0;
        end else begin
            cpu_reset <= (next_state == S_LOAD) || (next_state == S_WAIT_VS);
            dir_set   <= (next_state == S_APPLY);
        end
    end

    // Vsync edge detector and the vsync / apply-length counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d <= 1'b0;
            vs_cnt  <= 4'd0;
            ap_cnt  <= 4'd0;
        end else begin
            vsync_d <= vsync;
            if (state == S_LOAD && next_state == S_WAIT_VS) begin
                vs_cnt <= 4'd0;
            end else if (state == S_WAIT_VS && vs_rise) begin
                vs_cnt <= vs_cnt + 4'd1;
            end
            if (state != S_APPLY) begin
                ap_cnt <= 4'd0;
            end else begin
                ap_cnt <= ap_cnt + 4'd1;
            end
        end
    end

    // Load tracking: highest written address and whether a register page arrived.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_top  <= 16'h0000;
            regs_seen <= 1'b0;
        end else if (entering) begin
            load_top  <= loader_wr ? loader_addr : 16'h0000;
            regs_seen <= page_hit;
        end else if (wr_active) begin
            if (loader_addr > load_top) begin
                load_top <= loader_addr;
            end
            if (page_hit) begin
                regs_seen <= 1'b1;
            end
        end
    end

    // Register image capture, plus the SP substitution on the release edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir <= '0;
        end else begin
            if (page_hit) begin
                dir <= dir_wr;
            end
`ifdef ACE_SNAP_SP_FIX_EN
            // Dump tools sometimes leave SP above the loaded image; park it at a safe value.
            if (state == S_WAIT_VS && next_state == S_APPLY && dir[63:48] > load_top) begin
                dir[63:48] <= SP_FALLBACK;
            end
`else
            if (1'b0) begin
                dir <= dir;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ace_snap_restore.sv
// tb/tb_ace_snap_restore.sv - self-checking bench for ace_snap_restore
module tb_ace_snap_restore;

    logic           clk;
    logic           reset_n;
    logic           loader_en;
    logic [15:0]    loader_addr;
    logic [7:0]     loader_data;
    logic           loader_wr;
    logic           vsync;
    logic           cpu_reset;
    logic           dir_set;
    logic [211:0]   dir;
    logic [15:0]    load_top;
    logic           cpu_reset2;
    logic           dir_set2;
    logic [211:0]   dir2;
    logic [15:0]    load_top2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] off;
        logic [7:0] data;
        int         lsb;
        int         w;
    } vec_t;

    typedef struct {
        int          lsb;
        int          w;
        logic [15:0] val;
    } exp_t;

    vec_t         vecs[29];
    exp_t         sb[$];
    logic [211:0] model_dir;

    ace_snap_restore dut (
        .clk(clk), .reset_n(reset_n), .loader_en(loader_en), .loader_addr(loader_addr),
        .loader_data(loader_data), .loader_wr(loader_wr), .vsync(vsync),
        .cpu_reset(cpu_reset), .dir_set(dir_set), .dir(dir), .load_top(load_top)
    );

    ace_snap_restore #(.VSYNC_WAIT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .loader_en(loader_en), .loader_addr(loader_addr),
        .loader_data(loader_data), .loader_wr(loader_wr), .vsync(vsync),
        .cpu_reset(cpu_reset2), .dir_set(dir_set2), .dir(dir2), .load_top(load_top2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] field(input logic [211:0] d, input int lsb, input int w);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = d[lsb + b];
        return r;
    endfunction

    task automatic model_put(input int lsb, input int w, input logic [15:0] v);
        for (int b = 0; b < w; b++) model_dir[lsb + b] = v[b];
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        loader_en   = 1'b1;
        loader_wr   = 1'b1;
        loader_addr = a;
        loader_data = d;
        @(negedge clk);
        loader_wr   = 1'b0;
    endtask

    task automatic end_load();
        loader_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{7'h00, 8'h12,   8, 8};
        vecs[1]  = '{7'h01, 8'h34,   0, 8};
        vecs[2]  = '{7'h04, 8'h56,  80, 8};
        vecs[3]  = '{7'h05, 8'h78,  88, 8};
        vecs[4]  = '{7'h08, 8'h9A,  96, 8};
        vecs[5]  = '{7'h09, 8'hBC, 104, 8};
        vecs[6]  = '{7'h0C, 8'hDE, 112, 8};
        vecs[7]  = '{7'h0D, 8'h21, 120, 8};
        vecs[8]  = '{7'h10, 8'h43, 128, 8};
        vecs[9]  = '{7'h11, 8'h65, 136, 8};
        vecs[10] = '{7'h14, 8'h87, 192, 8};
        vecs[11] = '{7'h15, 8'hA9, 200, 8};
        vecs[12] = '{7'h18, 8'hF0,  48, 8};
        vecs[13] = '{7'h19, 8'h3F,  56, 8};
        vecs[14] = '{7'h1C, 8'h00,  64, 8};
        vecs[15] = '{7'h1D, 8'h04,  72, 8};
        vecs[16] = '{7'h20, 8'hCB,  24, 8};
        vecs[17] = '{7'h21, 8'hED,  16, 8};
        vecs[18] = '{7'h24, 8'h0F, 144, 8};
        vecs[19] = '{7'h25, 8'h1E, 152, 8};
        vecs[20] = '{7'h28, 8'h2D, 160, 8};
        vecs[21] = '{7'h29, 8'h3C, 168, 8};
        vecs[22] = '{7'h2C, 8'h4B, 176, 8};
        vecs[23] = '{7'h2D, 8'h5A, 184, 8};
        vecs[24] = '{7'h30, 8'hFE, 208, 2};
        vecs[25] = '{7'h34, 8'h03, 210, 1};
        vecs[26] = '{7'h38, 8'h81, 211, 1};
        vecs[27] = '{7'h3C, 8'h69,  32, 8};
        vecs[28] = '{7'h40, 8'h96,  40, 8};

        model_dir   = '0;
        reset_n     = 1'b0;
        loader_en   = 1'b0;
        loader_wr   = 1'b0;
        loader_addr = 16'h0000;
        loader_data = 8'h00;
        vsync       = 1'b0;

        // Reset state
        #1;
        chk("rst_cpu_reset", cpu_reset, 0);
        chk("rst_dir_set", dir_set, 0);
        chk("rst_dir", dir, 0);
        chk("rst_load_top", load_top, 0);
        chk("rst_regs_seen", dut.regs_seen, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Register page capture, one scoreboard entry per byte
        foreach (vecs[i]) begin
            exp_t e;
            e.lsb = vecs[i].lsb;
            e.w   = vecs[i].w;
            e.val = {8'h00, vecs[i].data} & ((16'h1 << vecs[i].w) - 16'h1);
            sb.push_back(e);
            model_put(e.lsb, e.w, e.val);
            wr({8'h21, 1'b0, vecs[i].off}, vecs[i].data);
            begin
                exp_t p;
                p = sb.pop_front();
                chk($sformatf("dir_field_%0d", p.lsb), field(dir, p.lsb, p.w), p.val);
            end
            chk($sformatf("load_cpu_reset_%0d", i), cpu_reset, 1);
        end
        wr(16'h7FFF, 8'hAA);
        chk("t1_load_top", load_top, 16'h7FFF);
        chk("t1_regs_seen", dut.regs_seen, 1);
        end_load();
        chk("t1_wait_cpu_reset", cpu_reset, 1);
        chk("t1_wait_dir_set", dir_set, 0);
        @(negedge clk);
        chk("t1_wait2_cpu_reset", cpu_reset, 1);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t1_rel_cpu_reset", cpu_reset, 0);
        chk("t1_dir_set_c1", dir_set, 1);
        chk("t1_sp", dir[63:48], 16'h3FF0);
        chk("t1_pc", dir[79:64], 16'h0400);
        chk("t1_dir_full", dir, model_dir);
        chk("t1_dut2_held", cpu_reset2, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t1_dir_set_c%0d", k + 2), dir_set, (k < 2) ? 1 : 0);
        end

        // SP fix
        wr(16'h2118, 8'h00);
        wr(16'h2119, 8'hFF);
        wr(16'h7FFF, 8'h00);
`ifdef ACE_SNAP_SP_FIX_EN
        model_dir[63:48] = 16'hFFFE;
`else
        model_dir[63:48] = 16'hFF00;
`endif
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t2_dir_set", dir_set, 1);
        chk("t2_sp", dir[63:48], model_dir[63:48]);
        repeat (4) @(negedge clk);
        chk("t2_end_dir_set", dir_set, 0);
        chk("t2_end_cpu_reset", cpu_reset, 0);

        // Plain memory load
        for (int a = 16'h4000; a <= 16'h40FF; a++) wr(16'(a), 8'(a));
        chk("t3_load_top", load_top, 16'h40FF);
        chk("t3_regs_seen", dut.regs_seen, 0);
        chk("t3_cpu_reset", cpu_reset, 1);
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t3_rel_cpu_reset", cpu_reset, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_dir_set_%0d", k), dir_set, 0);
            @(negedge clk);
        end
        chk("t3_dir_kept", dir, model_dir);

        // Ignored page addresses
        wr(16'h2180, 8'h5A);
        wr(16'h2102, 8'hA5);
        chk("t4_regs_seen", dut.regs_seen, 0);
        chk("t4_dir", dir, model_dir);
        chk("t4_load_top", load_top, 16'h2180);
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t4_cpu_reset", cpu_reset, 0);
        chk("t4_dir_set", dir_set, 0);
        repeat (2) @(negedge clk);

        // Loader restart against the two-edge instance; loader_en beats vsync
        wr(16'h2101, 8'h55);
        model_dir[7:0] = 8'h55;
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t5_dut2_edge1_cpu_reset", cpu_reset2, 1);
        chk("t5_dut_apply", dir_set, 1);
        @(negedge clk);
        loader_en = 1'b1;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t5_dut2_restart_cpu_reset", cpu_reset2, 1);
        chk("t5_dut2_restart_dir_set", dir_set2, 0);
        chk("t5_dut_abort_dir_set", dir_set, 0);
        chk("t5_dut_abort_cpu_reset", cpu_reset, 1);
        wr(16'h2140, 8'h77);
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t5_dut2_new_edge1", cpu_reset2, 1);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t5_dut2_edge2_cpu_reset", cpu_reset2, 0);
        chk("t5_dut2_edge2_dir_set", dir_set2, 1);
        chk("t5_dut2_r", dir2[47:40], 8'h77);
        repeat (5) @(negedge clk);

        // Reset during APPLY
        wr(16'h2101, 8'h66);
        end_load();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("t6_pre_dir_set", dir_set, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_dir_set", dir_set, 0);
        chk("t6_cpu_reset", cpu_reset, 0);
        chk("t6_dir", dir, 0);
        chk("t6_load_top", load_top, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_idle_cpu_reset", cpu_reset, 0);
        chk("t6_idle_dir_set", dir_set, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
